// File: rtl/gpu_pkg.sv
// Shared GPU-level constants and the shared-memory arbiter state encoding.
package gpu_pkg;

  localparam int N_CORES     = 16;
  localparam int SMEM_ADDR_W = 12;
  localparam int DATA_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } smem_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after i_ptr,
// wrapping modulo N, wins.
module rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_k;

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    w_k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = (int'(i_ptr) + i) % N;
      if (i_req[w_k]) begin
        o_grant      = '0;
        o_grant[w_k] = 1'b1;
        o_idx        = IDX_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/smem_arbiter.sv
// Round-robin arbiter sharing one single-port shared-memory SRAM among the
// cores; one access per four cycles, read data broadcast on ld_dat.
module smem_arbiter
  import gpu_pkg::*;
#(
  parameter int N_CORES = gpu_pkg::N_CORES,
  parameter int ADDR_W  = gpu_pkg::SMEM_ADDR_W,
  parameter int DATA_W  = gpu_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req_ld,
  input  logic [N_CORES-1:0]          req_st,
  input  logic [N_CORES*ADDR_W-1:0]   req_addr,
  input  logic [N_CORES*DATA_W-1:0]   req_wdata,
  output logic [N_CORES-1:0]          val_data,
  output logic [DATA_W-1:0]           ld_dat,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  smem_arb_state_t r_state, w_state_next;

  logic [N_CORES-1:0] w_req;
  logic [N_CORES-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_ld;
  logic [IDX_W-1:0]   w_ptr_next;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_win_idx;
  logic [N_CORES-1:0] r_win_oh;
  logic               r_is_ld;
  logic [N_CORES-1:0] r_val_data;
  logic [DATA_W-1:0]  r_ld_dat;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_busy;

  assign w_req = req_ld | req_st;

  rr_arbiter #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A core raising both ld and st is served as a load.
  assign w_sel_addr  = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_wdata = req_wdata[int'(w_idx)*DATA_W +: DATA_W];
  assign w_sel_ld    = req_ld[w_idx];
  assign w_ptr_next  = (r_win_idx == IDX_W'(N_CORES - 1)) ? '0 : r_win_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT:  w_state_next = ST_ACK;
      ST_ACK:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // The grant latches double as the SRAM command registers, so ISSUE drives them directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_win_idx   <= '0;
      r_win_oh    <= '0;
      r_is_ld     <= 1'b0;
      r_val_data  <= '0;
      r_ld_dat    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_val_data <= '0;
      r_busy     <= (w_state_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win_idx   <= w_idx;
            r_win_oh    <= w_grant;
            r_is_ld     <= w_sel_ld;
            r_mem_en    <= 1'b1;
            r_mem_we    <= ~w_sel_ld;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end
        end
        ST_WAIT: begin
          if (r_is_ld) r_ld_dat <= mem_rdata;
          r_val_data <= r_win_oh;
        end
        ST_ACK: r_rr_ptr <= w_ptr_next;
        default: ;
      endcase
    end
  end

  assign val_data  = r_val_data;
  assign ld_dat    = r_ld_dat;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
